mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_ctrl.sv | 105 ++++++++++
 tb/tb_mem_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the tristate-bus memory controller: default widths and FSM state encoding.
package mem_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int AWIDTH_DEF = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Single-port memory controller driving a shared tristate data bus with a fixed
// five-cycle SETUP/STROBE/HOLD/RESP access sequence and flop-driven strobes.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    inout  wire  [DWIDTH-1:0] mem_data,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write
);

    state_t            state_q;
    logic              ready_q;
    logic              we_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              drive_en_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              rsp_valid_q;
    logic [DWIDTH-1:0] rsp_rdata_q;

    // Every output below is taken straight from a flop; strobes are set one
    // state ahead so they are high exactly in the intended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            drive_en_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        we_q       <= req_we;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        drive_en_q <= req_we;
                        ready_q    <= 1'b0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    mem_write_q <= we_q;
                    mem_read_q  <= !we_q;
                    state_q     <= STROBE;
                end
                STROBE: begin
                    mem_write_q <= 1'b0;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (!we_q) begin
                        rsp_rdata_q <= mem_data;
                    end
                    mem_read_q  <= 1'b0;
                    drive_en_q  <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    drive_en_q  <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // The bus is released in RESP, giving the memory a full turnaround before any following read.
    assign mem_data  = drive_en_q ? wdata_q : {DWIDTH{1'bz}};
    assign mem_addr  = addr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with an attached 8-bit x 32-word memory on a pulled-up data bus.
module tb_mem_ctrl;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    tri1  [DW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;

    logic [DW-1:0] mem_arr [0:31];

    int vectors      = 0;
    int miscompares  = 0;
    int cyc          = 0;
    int last_rsp_cyc = -1;
    logic [DW-1:0] last_rd = '0;

    mem_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_data  (mem_data),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read while mem_read, capture on rising mem_write.
    assign mem_data = mem_read ? mem_arr[mem_addr] : {DW{1'bz}};
    always @(posedge mem_write) mem_arr[mem_addr] <= mem_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        chk("no_rw_overlap", 32'(mem_read & mem_write), 32'h0);
        if (req_ready) chk("idle_bus_z", 32'(mem_data), 32'hFF);
    endtask

    // One request from the IDLE cycle through the cycle after RESP (k+5).
    task automatic xfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd, input bit stall);
        logic [DW-1:0] exp_rsp;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        chk("ready_idle", 32'(req_ready), 32'h1);
        tick;
        if (stall) begin
            req_we    = 1'($urandom);
            req_addr  = 5'($urandom);
            req_wdata = 8'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        chk("setup_ready", 32'(req_ready), 32'h0);
        chk("setup_addr", 32'(mem_addr), 32'(addr));
        chk("setup_wr", 32'(mem_write), 32'h0);
        chk("setup_rd", 32'(mem_read), 32'h0);
        chk("setup_data", 32'(mem_data), we ? 32'(wd) : 32'hFF);
        tick;
        chk("strobe_wr", 32'(mem_write), 32'(we));
        chk("strobe_rd", 32'(mem_read), 32'(!we));
        chk("strobe_addr", 32'(mem_addr), 32'(addr));
        chk("strobe_data", 32'(mem_data), we ? 32'(wd) : 32'(exp_rd));
        tick;
        chk("hold_wr", 32'(mem_write), 32'h0);
        chk("hold_rd", 32'(mem_read), 32'(!we));
        chk("hold_addr", 32'(mem_addr), 32'(addr));
        chk("hold_data", 32'(mem_data), we ? 32'(wd) : 32'(exp_rd));
        chk("hold_rsp", 32'(rsp_valid), 32'h0);
        tick;
        exp_rsp = we ? last_rd : exp_rd;
        last_rd = exp_rsp;
        chk("resp_valid", 32'(rsp_valid), 32'h1);
        chk("resp_rdata", 32'(rsp_rdata), 32'(exp_rsp));
        chk("resp_strobes", 32'({mem_read, mem_write}), 32'h0);
        chk("resp_bus_z", 32'(mem_data), 32'hFF);
        chk("resp_ready", 32'(req_ready), 32'h0);
        if (stall && last_rsp_cyc >= 0) chk("rsp_spacing", 32'(cyc - last_rsp_cyc), 32'd5);
        last_rsp_cyc = cyc;
        tick;
        if (stall) req_valid = 1'b0;
        chk("post_ready", 32'(req_ready), 32'h1);
        chk("post_rsp", 32'(rsp_valid), 32'h0);
        $display("txn %s addr=0x%02h wdata=0x%02h rdata=0x%02h cyc=%0d",
                 we ? "WR" : "RD", addr, wd, rsp_rdata, cyc);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 32; i++) mem_arr[i] = '0;
        #2;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_strobes", 32'({mem_read, mem_write}), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_bus_z", 32'(mem_data), 32'hFF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("ready_after_rst", 32'(req_ready), 32'h1);

        // write then read
        xfer(1'b1, 5'h03, 8'hA5, 8'h00, 1'b0);
        xfer(1'b0, 5'h03, 8'h00, 8'hA5, 1'b0);

        // address boundaries
        xfer(1'b1, 5'h1F, 8'h5A, 8'h00, 1'b0);
        xfer(1'b1, 5'h00, 8'h3C, 8'h00, 1'b0);
        xfer(1'b0, 5'h1F, 8'h00, 8'h5A, 1'b0);
        xfer(1'b0, 5'h00, 8'h00, 8'h3C, 1'b0);

        // back-to-back with request inputs scrambled while busy
        last_rsp_cyc = -1;
        for (int a = 0; a < 32; a++) xfer(1'b1, 5'(a), 8'(a) ^ 8'hFF, 8'h00, 1'b1);
        for (int a = 0; a < 32; a++) xfer(1'b0, 5'(a), 8'h00, 8'(a) ^ 8'hFF, 1'b1);

        // reset during the write strobe
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 5'h07;
        req_wdata = 8'h11;
        tick;
        req_valid = 1'b0;
        tick;
        chk("abort_strobe_wr", 32'(mem_write), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_wr_low", 32'(mem_write), 32'h0);
        chk("abort_rd_low", 32'(mem_read), 32'h0);
        chk("abort_bus_z", 32'(mem_data), 32'hFF);
        chk("abort_rsp", 32'(rsp_valid), 32'h0);
        chk("abort_ready", 32'(req_ready), 32'h1);
        chk("abort_rdata", 32'(rsp_rdata), 32'h0);
        last_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("abort_ready_post", 32'(req_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_rsp", 32'(rsp_valid), 32'h0);
            tick;
        end
        xfer(1'b0, 5'h05, 8'h00, 8'hFA, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
